mem_burst_writer: RTL and testbench
===================================

# mem_burst_writer

Memory write initiator: accepts a burst request (base address, size code) plus a stream of 32-bit words and writes them into the `memory` module's port as consecutive word writes. It is the writer counterpart of `fetch`. `fetch` reads instructions out of memory; this block fills memory, replacing the bench-side image loader so that program images and stores go through one checked path.

## Interface
- `DATA_WIDTH`, 32, width of data words and memory data bus
- `ADDR_WIDTH`, 32, width of byte addresses
- `MAX_BURST`, 16, largest burst in words; also the depth of the verify buffer

- `clock`  in  1  single clock; all state changes on posedge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  burst request present
- `req_ready`  out  1  block idle and able to accept a request
- `req_addr`  in  ADDR_WIDTH  byte base address; must be word aligned
- `req_size`  in  2  burst code: 00 = 1 word, 01 = 4, 10 = 8, 11 = 16
- `wr_valid`  in  1  write word present
- `wr_ready`  out  1  word accepted this cycle when `wr_valid` is also high
- `wr_data`  in  DATA_WIDTH  word to write
- `mem_address`  out  ADDR_WIDTH  memory byte address
- `mem_data_in`  out  DATA_WIDTH  memory write data
- `mem_access_size`  out  2  always 2'b00 (single word)
- `mem_rw`  out  1  0 = write, 1 = read
- `mem_enable`  out  1  memory access this cycle
- `mem_busy`  in  1  memory cannot accept an access this cycle
- `mem_data_out`  in  DATA_WIDTH  read data; valid one cycle after an accepted read
- `done`  out  1  one-cycle pulse at the end of a burst
- `error`  out  1  qualified by `done`; high means a misaligned request or a verify mismatch

## Operation
- States: IDLE, WRITE, VERIFY (macro builds only), DONE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch `req_addr` into `cur_addr` and set `remaining` = burst length.
  - If `req_addr[1:0]` != 0, go to DONE with the error flag set; no memory access occurs.
  - Otherwise go to WRITE.
- WRITE:
  - `wr_ready` = !`mem_busy`.
  - On a handshake (`wr_valid` && `wr_ready`), in the same cycle and combinationally: `mem_enable` = 1, `mem_rw` = 0, `mem_address` = `cur_addr`, `mem_data_in` = `wr_data`.
  - At the edge: `cur_addr` += 4 (modulo 2^ADDR_WIDTH, wraps), `remaining` -= 1.
  - When the final word is accepted, go to VERIFY (macro) or DONE.
- DONE:
  - `done` = 1 for exactly one cycle, `error` = latched flag.
  - Then return to IDLE and clear the flag.
- `wr_valid` outside WRITE is ignored (`wr_ready` = 0).
- `req_valid` outside IDLE is ignored (`req_ready` = 0).
- Outside an access, `mem_enable` = 0 and `mem_rw` = 0; `mem_address` and `mem_data_in` are don't-care.

## Timing
- Reset values:
  - State IDLE; `req_ready` = 1.
  - `wr_ready`, `mem_enable`, `mem_rw`, `done`, `error` = 0.
  - `mem_access_size` = 00; `cur_addr`, `remaining` and the flag are cleared.
- Reset mid-burst: the burst is abandoned the next cycle (IDLE, no `done`). Words already written stay in memory.
- Write latency is 0: the word is written in its handshake cycle.
- An N-word burst with no stalls takes N WRITE cycles plus 1 DONE cycle. The next request is accepted the cycle after DONE.
- A misaligned request takes 1 cycle to DONE.
- `mem_busy` high blocks the handshake; the word is held by the producer and nothing is dropped.
- Simultaneous `mem_busy` and `wr_valid`: no write and no counter change.

## Configuration
- `MEM_WRITER_VERIFY_EN` defined:
  - Each accepted word is also stored in a MAX_BURST x DATA_WIDTH buffer.
  - After the last write, VERIFY re-reads from the base address with `mem_rw` = 1, `mem_enable` = 1, one read per non-busy cycle.
  - Each `mem_data_out` is compared one cycle after its read is issued; any mismatch sets the error flag.
  - DONE follows the compare of the last word, so an N-word burst adds N+1 cycles.
- Undefined: no buffer, no VERIFY state, `mem_rw` is always 0, and `error` only reports misalignment.

## Test plan
- Single word: request 0x80020000 with `req_size` 00, word 0x27BDFFF0 -> one cycle with `mem_enable` = 1, `mem_rw` = 0, address 0x80020000, data 0x27BDFFF0; `done` = 1 and `error` = 0 next cycle (no macro).
- 4-word burst at 0x80020010, `mem_busy` held high for 2 cycles before word 2 -> `wr_ready` low for those cycles; writes land at 0x..10, 0x..14, 0x..18, 0x..1C; `done` one cycle after the 4th write.
- Misaligned request 0x80020002 -> `done` = 1 and `error` = 1 on the next cycle; `mem_enable` never asserted; `req_ready` = 1 the cycle after.
- Wrap: base 0xFFFFFFF8, `req_size` 01 -> write addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset asserted after 2 of 16 words -> next cycle in IDLE with `req_ready` = 1; no `done` pulse; a new 1-word request then completes normally.
- `MEM_WRITER_VERIFY_EN`, 8-word burst:
  - Clean memory model -> 8 reads with `mem_rw` = 1 at the same addresses, then `done` = 1, `error` = 0.
  - Model corrupting word 5 -> `done` = 1, `error` = 1.

Source files
------------

// File: rtl/mem_burst_writer.sv
// mem_burst_writer: takes a burst request and streams words into memory as single-word writes.
// Define MEM_WRITER_VERIFY_EN to add a read-back compare of every burst before done.
module mem_burst_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [1:0]            mem_access_size,
  output logic                  mem_rw,
  output logic                  mem_enable,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  done,
  output logic                  error
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready high
  // WRITE  | one memory write per wr_valid/wr_ready handshake
  // VERIFY | re-read the burst and compare with the buffer (verify builds only)
  // DONE   | one-cycle done pulse, error = latched flag
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WRITE  = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam int         CNT_W    = $clog2(MAX_BURST + 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CNT_W-1:0]      remaining;
  logic                  err_flag;
  logic [CNT_W-1:0]      req_len;
  logic                  wr_fire;
  logic                  last_word;

  always_comb begin
    case (req_size)
      2'b00:   req_len = CNT_W'(1);
      2'b01:   req_len = CNT_W'(4);
      2'b10:   req_len = CNT_W'(8);
      default: req_len = CNT_W'(16);
    endcase
  end

  assign req_ready       = (state == S_IDLE);
  assign wr_ready        = (state == S_WRITE) && !mem_busy;
  assign wr_fire         = wr_valid && wr_ready;
  assign last_word       = (remaining == CNT_W'(1));
  assign done            = (state == S_DONE);
  assign error           = done && err_flag;
  assign mem_access_size = 2'b00;

`ifdef MEM_WRITER_VERIFY_EN
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam int         IDX_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [DATA_WIDTH-1:0] vbuf [MAX_BURST];
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_W-1:0]      burst_len;
  logic [IDX_W-1:0]      buf_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      pend_idx;
  logic                  pend;
  logic                  rd_fire;

  // In VERIFY, remaining counts reads still to issue.
  assign rd_fire = (state == S_VERIFY) && (remaining != '0) && !mem_busy;

  always_ff @(posedge clock) begin
    if (wr_fire) vbuf[buf_idx] <= wr_data;
  end
`else
  logic unused_rd_data;
  assign unused_rd_data = ^mem_data_out;
`endif

  always_comb begin
    mem_enable  = 1'b0;
    mem_rw      = 1'b0;
    mem_address = cur_addr;
    mem_data_in = wr_data;
    if (wr_fire) mem_enable = 1'b1;
`ifdef MEM_WRITER_VERIFY_EN
    if (rd_fire) begin
      mem_enable = 1'b1;
      mem_rw     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      err_flag  <= 1'b0;
`ifdef MEM_WRITER_VERIFY_EN
      base_addr <= '0;
      burst_len <= '0;
      buf_idx   <= '0;
      rd_idx    <= '0;
      pend_idx  <= '0;
      pend      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cur_addr  <= req_addr;
            remaining <= req_len;
`ifdef MEM_WRITER_VERIFY_EN
            base_addr <= req_addr;
            burst_len <= req_len;
            buf_idx   <= '0;
`endif
            if (req_addr[1:0] != 2'b00) begin
              err_flag <= 1'b1;
              state    <= S_DONE;
            end else begin
              state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (wr_fire) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(4);
            remaining <= remaining - CNT_W'(1);
`ifdef MEM_WRITER_VERIFY_EN
            buf_idx   <= buf_idx + IDX_W'(1);
            if (last_word) begin
              state     <= S_VERIFY;
              cur_addr  <= base_addr;
              remaining <= burst_len;
              rd_idx    <= '0;
              pend      <= 1'b0;
            end
`else
            if (last_word) state <= S_DONE;
`endif
          end
        end
`ifdef MEM_WRITER_VERIFY_EN
        S_VERIFY: begin
          // Read data returns one cycle after issue, so compare lags the read by one.
          pend     <= rd_fire;
          pend_idx <= rd_idx;
          if (pend && (mem_data_out != vbuf[pend_idx])) err_flag <= 1'b1;
          if (rd_fire) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(4);
            remaining <= remaining - CNT_W'(1);
            rd_idx    <= rd_idx + IDX_W'(1);
          end else if (remaining == '0) begin
            state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          state    <= S_IDLE;
          err_flag <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_writer.sv
// Bench for mem_burst_writer: randomized bursts against a burst-level expectation and a memory model.
// Verify-path cases are included when MEM_WRITER_VERIFY_EN is defined.
module tb_mem_burst_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic        mem_busy;
  logic [31:0] mem_data_out;
  logic        done;
  logic        error;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_img [logic [31:0]];
  logic        corrupt_on   = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;
  logic [31:0] rnd_addr;
  logic [1:0]  rnd_size;

  always #5 clock = ~clock;

  mem_burst_writer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
    .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy),
    .mem_data_out(mem_data_out), .done(done), .error(error)
  );

  // Memory model: writes land at the edge, reads return one cycle later, optional single-word corruption.
  always @(posedge clock) begin
    if (mem_enable && !mem_busy) begin
      if (!mem_rw) mem_img[mem_address] = mem_data_in;
      else mem_data_out <= (mem_img.exists(mem_address) ? mem_img[mem_address] : 32'h0)
                           ^ ((corrupt_on && mem_address == corrupt_addr) ? 32'h1 : 32'h0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_burst(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] w0,
                           input int busy_pct, input int stall_idx, input int stall_n,
                           input bit corrupt, input int corrupt_idx);
    int          n;
    int          idx = 0;
    int          rd = 0;
    int          cyc = 0;
    int          stall_left;
    bit          pend = 0;
    bit          cmp;
    bit          fin = 0;
    bit          seen_done = 0;
    bit          exp_err = 0;
    bit          busy;
    bit          hs;
    logic [31:0] words [16];
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 4 : (size == 2'b10) ? 8 : 16;
    stall_left = stall_n;
    foreach (words[i]) words[i] = $urandom;
    words[0] = w0;
    corrupt_on   = corrupt;
    corrupt_addr = addr + 32'(4 * corrupt_idx);

    @(negedge clock);
    req_valid = 1'b1; req_addr = addr; req_size = size; mem_busy = 1'b0; wr_valid = 1'b0;
    #1 chk("req_ready", req_ready, 1);
    @(negedge clock);
    req_valid = 1'b0;
    if (addr[1:0] != 2'b00) begin
      #1;
      chk("mis_done", done, 1);
      chk("mis_error", error, 1);
      chk("mis_enable", mem_enable, 0);
      @(negedge clock);
      #1;
      chk("mis_ready_after", req_ready, 1);
      chk("mis_done_clear", done, 0);
      corrupt_on = 1'b0;
      return;
    end

    while (!seen_done && cyc < 400) begin
      if (idx == stall_idx && stall_left > 0) begin
        busy = 1'b1;
        stall_left--;
      end else begin
        busy = ($urandom_range(0, 99) < busy_pct);
      end
      mem_busy = busy;
      wr_valid = (idx < n) && ($urandom_range(0, 3) != 0);
      wr_data  = (idx < n) ? words[idx] : $urandom;
      #1;
      chk("done", done, fin);
      chk("access_size", mem_access_size, 0);
      if (fin) begin
        chk("error", error, exp_err);
        seen_done = 1'b1;
      end else if (idx < n) begin
        hs = wr_valid && !busy;
        chk("wr_ready", wr_ready, !busy);
        chk("wr_enable", mem_enable, hs);
        chk("req_ready_busy", req_ready, 0);
        if (hs) begin
          chk("wr_rw", mem_rw, 0);
          chk("wr_addr", mem_address, addr + 32'(4 * idx));
          chk("wr_data", mem_data_in, words[idx]);
          idx++;
`ifndef MEM_WRITER_VERIFY_EN
          if (idx == n) fin = 1'b1;
`endif
        end
      end else begin
        cmp  = pend;
        pend = 1'b0;
        chk("vfy_wr_ready", wr_ready, 0);
        if (rd < n) begin
          chk("rd_enable", mem_enable, !busy);
          if (!busy) begin
            chk("rd_rw", mem_rw, 1);
            chk("rd_addr", mem_address, addr + 32'(4 * rd));
            if (corrupt && rd == corrupt_idx) exp_err = 1'b1;
            pend = 1'b1;
            rd++;
          end
        end else begin
          chk("rd_idle", mem_enable, 0);
          if (cmp) fin = 1'b1;
        end
      end
      cyc++;
      if (!seen_done) @(negedge clock);
    end
    chk("done_seen", seen_done, 1);
    wr_valid = 1'b0; mem_busy = 1'b0; corrupt_on = 1'b0;
  endtask

  task automatic reset_mid_burst();
    int hs_cnt = 0;
    int cyc = 0;
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h8002_0100; req_size = 2'b11; mem_busy = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    wr_valid  = 1'b1;
    while (hs_cnt < 2 && cyc < 50) begin
      wr_data = $urandom;
      #1;
      if (wr_ready && wr_valid) hs_cnt++;
      cyc++;
      @(negedge clock);
    end
    chk("rst_two_words", hs_cnt, 2);
    reset = 1'b1; wr_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_enable", mem_enable, 0);
    @(negedge clock);
    #1;
    chk("rst_done_later", done, 0);
    chk("rst_words_kept", 32'(mem_img.exists(32'h8002_0104)), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0;
    wr_valid = 1'b0; wr_data = '0; mem_busy = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_wr_ready", wr_ready, 0);
    chk("reset_enable", mem_enable, 0);
    chk("reset_rw", mem_rw, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_size", mem_access_size, 0);
    reset = 1'b0;

    run_burst(32'h8002_0000, 2'b00, 32'h27BD_FFF0, 0, -1, 0, 1'b0, 0);
    run_burst(32'h8002_0010, 2'b01, $urandom, 0, 1, 2, 1'b0, 0);
    run_burst(32'h8002_0002, 2'b01, $urandom, 0, -1, 0, 1'b0, 0);
    run_burst(32'hFFFF_FFF8, 2'b01, $urandom, 0, -1, 0, 1'b0, 0);
    reset_mid_burst();
    run_burst(32'h8002_0200, 2'b00, $urandom, 0, -1, 0, 1'b0, 0);
`ifdef MEM_WRITER_VERIFY_EN
    run_burst(32'h8002_0300, 2'b10, $urandom, 0, -1, 0, 1'b0, 0);
    run_burst(32'h8002_0400, 2'b10, $urandom, 0, -1, 0, 1'b1, 5);
`endif
    for (int i = 0; i < 30; i++) begin
      rnd_addr = $urandom;
      if ($urandom_range(0, 7) != 0) rnd_addr[1:0] = 2'b00;
      rnd_size = 2'($urandom_range(0, 3));
      run_burst(rnd_addr, rnd_size, $urandom, $urandom_range(0, 50), -1, 0,
                ($urandom_range(0, 3) == 0), $urandom_range(0, 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
